// File: rtl/sha_nonce_scheduler.sv
// Nonce scheduler for a fixed-latency, in-order SHA pipeline: issues {block, nonce} words and reports digests below target.
// Optional build macro SHA_SCHED_STOP_ON_HIT_EN: stop issuing on the first hit seen while issuing.
module sha_nonce_scheduler #(
    parameter int unsigned LATENCY = 66,
    parameter int unsigned NONCE_W = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 work_valid,
    output logic                 work_ready,
    input  logic [255-NONCE_W:0] work_block,
    input  logic [NONCE_W-1:0]   work_nonce_start,
    input  logic [NONCE_W-1:0]   work_nonce_count,
    input  logic [255:0]         target,
    input  logic                 abort,
    output logic                 pipe_write_en,
    output logic [255:0]         pipe_block_in,
    input  logic                 pipe_valid_out,
    input  logic [255:0]         pipe_digest_out,
    output logic                 hit_valid,
    output logic [NONCE_W-1:0]   hit_nonce,
    input  logic                 hit_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 hit_lost
);
    localparam int unsigned BLK_W  = 256 - NONCE_W;
    // One issue per cycle with a fixed latency bounds the results outstanding at once.
    localparam int unsigned INFL_W = $clog2(LATENCY + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [BLK_W-1:0]     blk_q, blk_d;
    logic [255:0]         target_q, target_d;
    logic [NONCE_W-1:0]   next_nonce_q, next_nonce_d;
    logic [NONCE_W-1:0]   remain_q, remain_d;
    logic [NONCE_W-1:0]   res_nonce_q, res_nonce_d;
    logic [INFL_W-1:0]    infl_q, infl_d;
    logic                 squash_q, squash_d;
    logic                 work_ready_q, work_ready_d;
    logic                 pipe_write_en_q, pipe_write_en_d;
    logic [255:0]         pipe_block_in_q, pipe_block_in_d;
    logic                 hit_valid_q, hit_valid_d;
    logic [NONCE_W-1:0]   hit_nonce_q, hit_nonce_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 hit_lost_q, hit_lost_d;

    logic                 accept_c;
    logic                 res_fire_c;
    logic                 hit_c;
    logic                 stop_c;

    // Next-state and registered-output logic
    always_comb begin
        state_d         = state_q;
        blk_d           = blk_q;
        target_d        = target_q;
        next_nonce_d    = next_nonce_q;
        remain_d        = remain_q;
        res_nonce_d     = res_nonce_q;
        squash_d        = squash_q;
        pipe_write_en_d = 1'b0;
        pipe_block_in_d = pipe_block_in_q;
        hit_valid_d     = hit_valid_q;
        hit_nonce_d     = hit_nonce_q;
        hit_lost_d      = hit_lost_q;
        done_d          = 1'b0;

        accept_c   = work_valid && work_ready_q && (state_q == IDLE);
        // Results with nothing outstanding cannot belong to this job.
        res_fire_c = pipe_valid_out && (infl_q != '0);
        hit_c      = res_fire_c && (pipe_digest_out < target_q) && !squash_q;
`ifdef SHA_SCHED_STOP_ON_HIT_EN
        stop_c     = abort || hit_c;
`else
        stop_c     = abort;
`endif

        infl_d = infl_q + INFL_W'(pipe_write_en_q) - INFL_W'(res_fire_c);
        if (res_fire_c) begin
            res_nonce_d = res_nonce_q + NONCE_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    blk_d       = work_block;
                    target_d    = target;
                    res_nonce_d = work_nonce_start;
                    squash_d    = 1'b0;
                    if (work_nonce_count == '0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d         = ISSUE;
                        pipe_write_en_d = 1'b1;
                        pipe_block_in_d = {work_block, work_nonce_start};
                        next_nonce_d    = work_nonce_start + NONCE_W'(1);
                        remain_d        = work_nonce_count - NONCE_W'(1);
                    end
                end
            end
            ISSUE: begin
                // pipe_write_en_q is high for the issue in flight this cycle.
                if (stop_c || (remain_q == '0)) begin
                    state_d = DRAIN;
                    if (abort) begin
                        squash_d = 1'b1;
                    end
                end else begin
                    pipe_write_en_d = 1'b1;
                    pipe_block_in_d = {blk_q, next_nonce_q};
                    next_nonce_d    = next_nonce_q + NONCE_W'(1);
                    remain_d        = remain_q - NONCE_W'(1);
                end
            end
            DRAIN: begin
                if (infl_d == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Hit handshake: a held, unacknowledged hit wins over a newer one.
        if (hit_valid_q && !hit_ready) begin
            if (hit_c) begin
                hit_lost_d = 1'b1;
            end
        end else begin
            hit_valid_d = hit_c;
            if (hit_c) begin
                hit_nonce_d = res_nonce_q;
            end
        end
        if (accept_c) begin
            hit_lost_d = 1'b0;
        end

        work_ready_d = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q         <= IDLE;
            blk_q           <= '0;
            target_q        <= '0;
            next_nonce_q    <= '0;
            remain_q        <= '0;
            res_nonce_q     <= '0;
            infl_q          <= '0;
            squash_q        <= 1'b0;
            work_ready_q    <= 1'b1;
            pipe_write_en_q <= 1'b0;
            pipe_block_in_q <= '0;
            hit_valid_q     <= 1'b0;
            hit_nonce_q     <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            hit_lost_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            blk_q           <= blk_d;
            target_q        <= target_d;
            next_nonce_q    <= next_nonce_d;
            remain_q        <= remain_d;
            res_nonce_q     <= res_nonce_d;
            infl_q          <= infl_d;
            squash_q        <= squash_d;
            work_ready_q    <= work_ready_d;
            pipe_write_en_q <= pipe_write_en_d;
            pipe_block_in_q <= pipe_block_in_d;
            hit_valid_q     <= hit_valid_d;
            hit_nonce_q     <= hit_nonce_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            hit_lost_q      <= hit_lost_d;
        end
    end

    assign work_ready    = work_ready_q;
    assign pipe_write_en = pipe_write_en_q;
    assign pipe_block_in = pipe_block_in_q;
    assign hit_valid     = hit_valid_q;
    assign hit_nonce     = hit_nonce_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign hit_lost      = hit_lost_q;

endmodule

// File: doc/sha_nonce_scheduler.md
SHA_NONCE_SCHEDULER -- requirements
Module: sha_nonce_scheduler

Interface
REQ-001 SHALL have parameter LATENCY, default 66: cycles from pipe_write_en high to the matching pipe_valid_out high.
REQ-002 SHALL have parameter NONCE_W, default 32: nonce width.
REQ-003 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port work_valid  in  1  new job offered.
REQ-006 SHALL have port work_ready  out  1  scheduler accepts a job.
REQ-007 SHALL have port work_block  in  256-NONCE_W  fixed upper bits of pipeline input.
REQ-008 SHALL have port work_nonce_start  in  NONCE_W  first nonce.
REQ-009 SHALL have port work_nonce_count  in  NONCE_W  number of nonces to issue.
REQ-010 SHALL have port target  in  256  hit threshold, latched on accept.
REQ-011 SHALL have port abort  in  1  cancel current job.
REQ-012 SHALL have port pipe_write_en  out  1  issue to hash pipeline.
REQ-013 SHALL have port pipe_block_in  out  256  {work_block, nonce}.
REQ-014 SHALL have ports pipe_valid_out  in  1  and  pipe_digest_out  in  256  pipeline result.
REQ-015 SHALL have ports hit_valid  out  1,  hit_nonce  out  NONCE_W,  hit_ready  in  1  hit handshake.
REQ-016 SHALL have ports busy  out  1,  done  out  1  (one-cycle pulse),  hit_lost  out  1  (sticky).

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE; work_ready=1 only in IDLE; a job is accepted when work_valid & work_ready.
REQ-018 On accept, SHALL latch work_block, target, start, count; count=0 goes directly to DRAIN.
REQ-019 In ISSUE, SHALL assert pipe_write_en every cycle with nonce = start+k (k=0..count-1, modulo 2^NONCE_W), no bubbles; after the last issue SHALL enter DRAIN.
REQ-020 SHALL keep an in-flight counter: +1 per issue, -1 per pipe_valid_out, net 0 on same-cycle events; DRAIN -> IDLE when counter is 0, with done=1 for exactly that cycle.
REQ-021 SHALL recover result nonces with a result counter reset to start on accept and incremented per pipe_valid_out (pipeline is in-order).
REQ-022 A result is a hit when pipe_digest_out < target (unsigned 256-bit); hit_valid/hit_nonce register it one cycle after pipe_valid_out.
REQ-023 hit_valid SHALL hold, with hit_nonce stable, until hit_ready; a new hit arriving while hit_valid & !hit_ready SHALL be dropped and set hit_lost; a hit on the same cycle hit_ready completes the old one SHALL be accepted.
REQ-024 abort in ISSUE SHALL stop issuing next cycle and enter DRAIN; in-flight results are still counted but not reported as hits; abort in IDLE/DRAIN has no further effect.
REQ-025 busy SHALL be 1 in ISSUE and DRAIN.
REQ-026 pipe_valid_out while in-flight counter is 0 SHALL be ignored.

Reset
REQ-027 RST low SHALL immediately force IDLE, clear counters, and drive work_ready=1, pipe_write_en=0, pipe_block_in=0, hit_valid=0, hit_nonce=0, busy=0, done=0, hit_lost=0; mid-job state is discarded.
REQ-028 hit_lost SHALL clear only on reset or on job accept.

Configuration
REQ-029 With SHA_SCHED_STOP_ON_HIT_EN defined, the first hit in ISSUE SHALL stop issuing (as abort, but in-flight hits still reported); undefined, the full range is always issued.

Verification
REQ-030 count=4, start=0xFFFFFFFE: pipe_block_in nonces FFFFFFFE, FFFFFFFF, 00000000, 00000001 on four consecutive cycles; done LATENCY+4 cycles after accept (±1).
REQ-031 Model pipeline returns digest 0x00..01 for nonce 5, target=0x00..0100, start=0, count=10: exactly one hit, hit_nonce=5.
REQ-032 Hits on nonces 2 and 3, hit_ready held 0: hit_nonce=2 held, hit_lost=1; release hit_ready: no second hit.
REQ-033 count=0: done pulse with no pipe_write_en ever asserted.
REQ-034 abort after 3 issues of count=100: exactly 3 pipe_write_en, done after 3 results, no hits reported.
REQ-035 RST low mid-ISSUE: all outputs at reset values same cycle; then a new job issues from its own start.
